// File: rtl/lol_pkg.sv
// lol_pkg: letter codes, column ROM and writer state shared by the column letter
// protocol writer, reader and bench model.
package lol_pkg;
  localparam logic [1:0] LOL_NONE = 2'b00;
  localparam logic [1:0] LOL_L = 2'b01;
  localparam logic [1:0] LOL_O = 2'b10;
  localparam logic [1:0] LOL_Y = 2'b11;
  localparam logic [2:0] COL_BLANK = 3'b000;
  localparam logic [2:0] COL_FULL = 3'b111;
  localparam logic [2:0] COL_BASE = 3'b001;
  localparam logic [2:0] COL_SIDES = 3'b101;
  localparam logic [2:0] COL_TOP = 3'b100;
  localparam logic [2:0] COL_MID = 3'b011;
  localparam int LEN_L = 3;
  localparam int LEN_O = 4;
  localparam int LEN_Y = 4;
  typedef enum logic {IDLE, SEND} state_t;
  // Returns {column, last}; last marks the terminator column of the letter.
  function automatic logic [3:0] lol_col(input logic [1:0] letter, input logic [2:0] idx);
    logic [2:0] c;
    logic [2:0] len;
    len = (letter == LOL_L) ? 3'(LEN_L) : (letter == LOL_O) ? 3'(LEN_O) : 3'(LEN_Y);
    case ({letter, idx})
      {LOL_L, 3'd0}, {LOL_O, 3'd0}, {LOL_O, 3'd2}: c = COL_FULL;
      {LOL_L, 3'd1}: c = COL_BASE;
      {LOL_O, 3'd1}: c = COL_SIDES;
      {LOL_Y, 3'd0}, {LOL_Y, 3'd2}: c = COL_TOP;
      {LOL_Y, 3'd1}: c = COL_MID;
      default: c = COL_BLANK;
    endcase
    return {c, idx == len - 3'd1};
  endfunction
endpackage

// File: rtl/lol_fifo.sv
// lol_fifo: QDEPTH-entry queue of 2-bit letter codes with synchronous restart.
module lol_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [1:0] i_data,
  output logic [1:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(QDEPTH);
  logic [1:0] r_mem [QDEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  // A full queue refuses pushes even when a pop frees a slot on the same edge.
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_full = r_cnt == (AW+1)'(QDEPTH);
  assign o_empty = r_cnt == '0;
  assign o_data = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (restart) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/lol_writer.sv
// lol_writer: serialises queued L/O/Y letter requests onto the 3-bit column bus.
// LOL_WRITER_LEAD_BLANK_EN: drive one extra 000 column ahead of every letter.
module lol_writer #(
  parameter int QDEPTH = 4
) (
  input  logic       clk,
  input  logic       restart,
  input  logic [1:0] letter_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic [2:0] bits,
  output logic       busy,
  output logic       done
);
  import lol_pkg::*;
  state_t r_state, w_state_n;
  logic [1:0] r_letter, w_letter_n, w_head;
  logic [2:0] r_idx, w_idx_n, r_bits, w_bits_n, w_start_bits, w_start_idx;
  logic r_busy, w_busy_n, r_done, w_done_n, w_start_done;
  logic w_full, w_empty, w_push, w_pop;
  logic [3:0] w_cur_col;
  lol_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .restart(restart),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(letter_in),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign ready_out = !w_full;
  assign w_push = valid_in && letter_in != LOL_NONE;
  assign w_cur_col = lol_col(r_letter, r_idx);
`ifdef LOL_WRITER_LEAD_BLANK_EN
  assign {w_start_bits, w_start_done} = {COL_BLANK, 1'b0};
  assign w_start_idx = 3'd0;
`else
  assign {w_start_bits, w_start_done} = lol_col(w_head, 3'd0);
  assign w_start_idx = 3'd1;
`endif
  // A new letter may start from IDLE or on the edge right after a terminator.
  always_comb begin
    w_pop = (r_state == IDLE || r_done) && !w_empty;
    w_state_n = r_state;
    w_letter_n = r_letter;
    w_idx_n = r_idx;
    w_bits_n = r_bits;
    w_busy_n = r_busy;
    w_done_n = 1'b0;
    if (w_pop) begin
      w_state_n = SEND;
      w_letter_n = w_head;
      w_idx_n = w_start_idx;
      w_bits_n = w_start_bits;
      w_busy_n = 1'b1;
      w_done_n = w_start_done;
    end else if (r_state == IDLE || r_done) begin
      w_state_n = IDLE;
      w_idx_n = 3'd0;
      w_bits_n = COL_BLANK;
      w_busy_n = 1'b0;
    end else begin
      w_bits_n = w_cur_col[3:1];
      w_done_n = w_cur_col[0];
      w_idx_n = r_idx + 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (restart) begin
      r_state <= IDLE;
      r_letter <= LOL_NONE;
      r_idx <= 3'd0;
      r_bits <= COL_BLANK;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_letter <= w_letter_n;
      r_idx <= w_idx_n;
      r_bits <= w_bits_n;
      r_busy <= w_busy_n;
      r_done <= w_done_n;
    end
  end
  assign bits = r_bits;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_lol_writer.sv
// tb_lol_writer: scoreboard bench for lol_writer; expected {bits,done} columns are
// queued when a letter is accepted and popped on every busy cycle.
module tb_lol_writer;
  logic clk = 1'b0, restart = 1'b1, valid_in = 1'b0;
  logic [1:0] letter_in = 2'b00;
  logic ready_out, busy, done;
  logic [2:0] bits;
  logic [3:0] q [$];
  int n_cmp = 0, n_bad = 0;
`ifdef LOL_WRITER_LEAD_BLANK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif
  lol_writer #(.QDEPTH(4)) dut (
    .clk(clk),
    .restart(restart),
    .letter_in(letter_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .bits(bits),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  function automatic void expect_letter(input logic [1:0] l);
    if (BL == 1) q.push_back(4'b0000);
    case (l)
      2'b01: begin
        q.push_back(4'b1110); q.push_back(4'b0010); q.push_back(4'b0001);
      end
      2'b10: begin
        q.push_back(4'b1110); q.push_back(4'b1010); q.push_back(4'b1110); q.push_back(4'b0001);
      end
      2'b11: begin
        q.push_back(4'b1000); q.push_back(4'b0110); q.push_back(4'b1000); q.push_back(4'b0001);
      end
      default: ;
    endcase
  endfunction
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bits !== 3'b000) begin n_bad++; $display("FAIL reset_bits got=%b want=000", bits); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", ready_out); end
    restart = 1'b0;
  endtask
  task automatic test_single_l();
    logic [3:0] e;
    int first = -1, dones = 0;
    valid_in = 1'b1; letter_in = 2'b01; expect_letter(2'b01);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (busy === 1'b1 && first < 0) first = i;
      if (done === 1'b1) dones++;
      n_cmp++;
      if (busy !== 1'b1) begin
        if ({bits, done} !== 4'b0) begin n_bad++; $display("FAIL single_idle i=%0d got=%b/%b want=000/0", i, bits, done); end
      end else if (q.size() == 0) begin
        n_bad++; $display("FAIL single_extra i=%0d got=%b/%b want=no column", i, bits, done);
      end else begin
        e = q.pop_front();
        if ({bits, done} !== e) begin n_bad++; $display("FAIL single_col i=%0d got=%b/%b want=%b/%b", i, bits, done, e[3:1], e[0]); end
      end
    end
    n_cmp++; if (first != 1) begin n_bad++; $display("FAIL single_latency got=%0d want=1", first); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL single_dones got=%0d want=1", dones); end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL single_left got=%0d want=0", q.size()); end
  endtask
  task automatic test_back_to_back();
    logic [3:0] e;
    int d [3];
    int nd = 0, nbusy = 0;
    @(negedge clk);
    valid_in = 1'b1; letter_in = 2'b10; expect_letter(2'b10);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (nd < 3) d[nd] = i;
        nd++;
      end
      if (busy === 1'b1) nbusy++;
      n_cmp++;
      if (busy !== 1'b1) begin
        if ({bits, done} !== 4'b0) begin n_bad++; $display("FAIL b2b_idle i=%0d got=%b/%b want=000/0", i, bits, done); end
      end else if (q.size() == 0) begin
        n_bad++; $display("FAIL b2b_extra i=%0d got=%b/%b want=no column", i, bits, done);
      end else begin
        e = q.pop_front();
        if ({bits, done} !== e) begin n_bad++; $display("FAIL b2b_col i=%0d got=%b/%b want=%b/%b", i, bits, done, e[3:1], e[0]); end
      end
      if (i == 0) begin letter_in = 2'b11; expect_letter(2'b11); end
      if (i == 1) begin letter_in = 2'b01; expect_letter(2'b01); end
      if (i == 2) valid_in = 1'b0;
    end
    n_cmp++; if (nd != 3) begin n_bad++; $display("FAIL b2b_dones got=%0d want=3", nd); end
    else begin
      n_cmp++; if (d[0] != 4 + BL) begin n_bad++; $display("FAIL b2b_done0 got=%0d want=%0d", d[0], 4 + BL); end
      n_cmp++; if (d[1] - d[0] != 4 + BL) begin n_bad++; $display("FAIL b2b_gap01 got=%0d want=%0d", d[1] - d[0], 4 + BL); end
      n_cmp++; if (d[2] - d[1] != 3 + BL) begin n_bad++; $display("FAIL b2b_gap12 got=%0d want=%0d", d[2] - d[1], 3 + BL); end
    end
    n_cmp++; if (nbusy != 11 + 3 * BL) begin n_bad++; $display("FAIL b2b_busy got=%0d want=%0d", nbusy, 11 + 3 * BL); end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL b2b_left got=%0d want=0", q.size()); end
  endtask
  task automatic test_full();
    logic [3:0] e;
    logic [1:0] seq [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
`ifdef LOL_WRITER_LEAD_BLANK_EN
    logic exp_r [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    logic exp_r [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    int k = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
        if ({bits, done} !== 4'b0) begin n_bad++; $display("FAIL full_idle t=%0d got=%b/%b want=000/0", t, bits, done); end
      end else if (q.size() == 0) begin
        n_bad++; $display("FAIL full_extra t=%0d got=%b/%b want=no column", t, bits, done);
      end else begin
        e = q.pop_front();
        if ({bits, done} !== e) begin n_bad++; $display("FAIL full_col t=%0d got=%b/%b want=%b/%b", t, bits, done, e[3:1], e[0]); end
      end
      if (t < $size(exp_r)) begin
        n_cmp++;
        if (ready_out !== exp_r[t]) begin n_bad++; $display("FAIL full_ready t=%0d got=%b want=%b", t, ready_out, exp_r[t]); end
      end
      valid_in = k < 6;
      if (k < 6) begin
        letter_in = seq[k];
        if (t < $size(exp_r) && exp_r[t]) begin expect_letter(seq[k]); k++; end
      end
    end
    n_cmp++; if (k != 6) begin n_bad++; $display("FAIL full_accepted got=%0d want=6", k); end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL full_left got=%0d want=0", q.size()); end
  endtask
  task automatic test_illegal();
    logic [3:0] e;
    int nbusy = 0;
    valid_in = 1'b1; letter_in = 2'b00;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
      n_cmp++;
      if (busy !== 1'b1) begin
        if ({bits, done} !== 4'b0) begin n_bad++; $display("FAIL illegal_idle i=%0d got=%b/%b want=000/0", i, bits, done); end
      end else if (q.size() == 0) begin
        n_bad++; $display("FAIL illegal_extra i=%0d got=%b/%b want=no column", i, bits, done);
      end else begin
        e = q.pop_front();
        if ({bits, done} !== e) begin n_bad++; $display("FAIL illegal_col i=%0d got=%b/%b want=%b/%b", i, bits, done, e[3:1], e[0]); end
      end
      if (i == 0) begin
        n_cmp++;
        if (ready_out !== 1'b1) begin n_bad++; $display("FAIL illegal_ready got=%b want=1", ready_out); end
        valid_in = 1'b0;
      end
      if (i == 3) begin valid_in = 1'b1; letter_in = 2'b11; expect_letter(2'b11); end
      if (i == 4) valid_in = 1'b0;
    end
    n_cmp++; if (nbusy != 4 + BL) begin n_bad++; $display("FAIL illegal_busy got=%0d want=%0d", nbusy, 4 + BL); end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL illegal_left got=%0d want=0", q.size()); end
  endtask
  task automatic test_restart_mid();
    logic [3:0] e;
    valid_in = 1'b1; letter_in = 2'b10; expect_letter(2'b10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
        if ({bits, done} !== 4'b0) begin n_bad++; $display("FAIL rst_idle i=%0d got=%b/%b want=000/0", i, bits, done); end
      end else if (q.size() == 0) begin
        n_bad++; $display("FAIL rst_extra i=%0d got=%b/%b want=no column", i, bits, done);
      end else begin
        e = q.pop_front();
        if ({bits, done} !== e) begin n_bad++; $display("FAIL rst_col i=%0d got=%b/%b want=%b/%b", i, bits, done, e[3:1], e[0]); end
      end
      if (i == 0) begin letter_in = 2'b01; expect_letter(2'b01); end
      if (i == 1) begin letter_in = 2'b11; expect_letter(2'b11); end
      if (i == 2) begin restart = 1'b1; valid_in = 1'b0; q.delete(); end
      if (i == 3) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_cmp++; if (bits !== 3'b000) begin n_bad++; $display("FAIL rst_bits got=%b want=000", bits); end
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b want=1", ready_out); end
        restart = 1'b0;
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_l();
    test_back_to_back();
    test_full();
    test_illegal();
    test_restart_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
